fetch_exec_sequencer: RTL and testbench

FETCH_EXEC_SEQUENCER -- requirements
Module: fetch_exec_sequencer

---
 rtl/fetch_exec_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fetch_exec_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_exec_sequencer.sv
// Fetch/decode/execute control FSM: Moore strobe decode of the state register; en/inc_PC also qualified by run/mem_ready.
// Zero-wait NOP takes 4 cycles F0..F0; wait states stall on mem_ready and fault after MEM_TIMEOUT idle cycles.
module fetch_exec_sequencer #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       mem_ready,
  input  logic [7:0] ir,
  output logic       PC_in,
  output logic       PC_out,
  output logic       inc_PC,
  output logic       MAR_in,
  output logic       MAR_mramout,
  output logic       data_in,
  output logic       data_out,
  output logic       dram_in,
  output logic       dram_out,
  output logic       IR_in,
  output logic       IR_out,
  output logic       Y_in,
  output logic       en,
  output logic [3:0] state,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    F0    = 4'd1,
    F1    = 4'd2,
    F2    = 4'd3,
    DEC   = 4'd4,
    LD0   = 4'd5,
    LD1   = 4'd6,
    LD2   = 4'd7,
    ST0   = 4'd8,
    ST1   = 4'd9,
    JMP   = 4'd10,
    HALT  = 4'd11,
    FAULT = 4'd12
  } state_e;

  localparam logic [3:0] TIMEOUT = 4'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       halted_q, halted_d;
  logic       fault_q, fault_d;
  logic       timeout;

  // A ready in the limit cycle wins, so timeout is only evaluated with mem_ready low.
  assign timeout = !mem_ready && ((wait_cnt_q + 4'd1) == TIMEOUT);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      IDLE: if (run) state_d = F0;
      F0:   state_d = F1;
      F1: begin
        if (mem_ready)    state_d = F2;
        else if (timeout) state_d = FAULT;
        else              wait_cnt_d = wait_cnt_q + 4'd1;
      end
      F2:   state_d = DEC;
      DEC: begin
        case (ir[7:4])
          4'h0:    state_d = F0;
          4'h1:    state_d = LD0;
          4'h2:    state_d = ST0;
          4'h3:    state_d = JMP;
          4'hF:    state_d = HALT;
          default: state_d = FAULT;
        endcase
      end
      LD0:  state_d = LD1;
      LD1: begin
        if (mem_ready)    state_d = LD2;
        else if (timeout) state_d = FAULT;
        else              wait_cnt_d = wait_cnt_q + 4'd1;
      end
      LD2:  state_d = F0;
      ST0:  state_d = ST1;
      ST1: begin
        if (mem_ready)    state_d = F0;
        else if (timeout) state_d = FAULT;
        else              wait_cnt_d = wait_cnt_q + 4'd1;
      end
      JMP:   state_d = F0;
      HALT:  state_d = HALT;
      FAULT: state_d = FAULT;
      default: state_d = FAULT;
    endcase
    halted_d = halted_q | (state_d == HALT);
    fault_d  = fault_q | (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    PC_in       = 1'b0;
    PC_out      = 1'b0;
    inc_PC      = 1'b0;
    MAR_in      = 1'b0;
    MAR_mramout = 1'b0;
    data_in     = 1'b0;
    data_out    = 1'b0;
    dram_in     = 1'b0;
    dram_out    = 1'b0;
    IR_in       = 1'b0;
    IR_out      = 1'b0;
    Y_in        = 1'b0;
    en          = 1'b0;
    case (state_q)
      // en is held low while reset is asserted even though the state already reads IDLE.
      IDLE: en = run & reset;
      F0: begin
        PC_out = 1'b1;
        MAR_in = 1'b1;
      end
      F1: begin
        MAR_mramout = 1'b1;
        dram_out    = 1'b1;
        data_in     = 1'b1;
        inc_PC      = mem_ready;
      end
      F2: begin
        data_out = 1'b1;
        IR_in    = 1'b1;
      end
      LD0, ST0: begin
        IR_out = 1'b1;
        MAR_in = 1'b1;
      end
      LD1: begin
        MAR_mramout = 1'b1;
        dram_out    = 1'b1;
        data_in     = 1'b1;
      end
      LD2: begin
        data_out = 1'b1;
        Y_in     = 1'b1;
      end
      ST1: begin
        MAR_mramout = 1'b1;
        dram_in     = 1'b1;
      end
      JMP: begin
        IR_out = 1'b1;
        PC_in  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state  = state_q;
  assign halted = halted_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Randomised instruction streams checked cycle by cycle against an instruction-level model of the sequencer.
module tb_fetch_exec_sequencer;
  localparam int TMO = 8;

  localparam int ST_IDLE = 0, ST_F0 = 1, ST_F1 = 2, ST_F2 = 3, ST_DEC = 4, ST_LD0 = 5,
                 ST_LD1 = 6, ST_LD2 = 7, ST_ST0 = 8, ST_ST1 = 9, ST_JMP = 10,
                 ST_HALT = 11, ST_FAULT = 12;

  localparam logic [12:0] S_PCIN = 13'h1000, S_PCO  = 13'h0800, S_INC  = 13'h0400,
                          S_MARI = 13'h0200, S_MRO  = 13'h0100, S_DIN  = 13'h0080,
                          S_DOUT = 13'h0040, S_DRIN = 13'h0020, S_DRO  = 13'h0010,
                          S_IRIN = 13'h0008, S_IRO  = 13'h0004, S_YIN  = 13'h0002,
                          S_EN   = 13'h0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       mem_ready = 1'b0;
  logic [7:0] ir = 8'h00;
  logic       PC_in, PC_out, inc_PC, MAR_in, MAR_mramout, data_in, data_out;
  logic       dram_in, dram_out, IR_in, IR_out, Y_in, en;
  logic [3:0] state;
  logic       halted, fault;
  logic [12:0] stb;

  int  n_chk = 0;
  int  n_fail = 0;
  bit  mdl_halted = 1'b0;
  bit  mdl_fault = 1'b0;

  fetch_exec_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PC_in(PC_in), .PC_out(PC_out), .inc_PC(inc_PC), .MAR_in(MAR_in),
    .MAR_mramout(MAR_mramout), .data_in(data_in), .data_out(data_out),
    .dram_in(dram_in), .dram_out(dram_out), .IR_in(IR_in), .IR_out(IR_out),
    .Y_in(Y_in), .en(en), .state(state), .halted(halted), .fault(fault)
  );

  assign stb = {PC_in, PC_out, inc_PC, MAR_in, MAR_mramout, data_in, data_out,
                dram_in, dram_out, IR_in, IR_out, Y_in, en};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rir();
    return 8'($urandom);
  endfunction

  function automatic int rdelay();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return TMO;
    if (r == 1) return TMO - 1;
    return $urandom_range(0, 3);
  endfunction

  // One clock cycle: drive inputs at the falling edge, then compare against the model's expectation.
  task automatic cyc(input int st, input logic [12:0] se, input logic run_v,
                     input logic mr_v, input logic [7:0] ir_v);
    @(negedge clk);
    run = run_v;
    mem_ready = mr_v;
    ir = ir_v;
    #1;
    check("state", 32'(state), 32'(st));
    check("strobes", 32'(stb), 32'(se));
    check("halted", 32'(halted), 32'(mdl_halted));
    check("fault", 32'(fault), 32'(mdl_fault));
    check("bus_excl", 32'($countones({PC_out, IR_out, data_out, dram_out}) <= 1), 32'd1);
  endtask

  // Memory access that completes after d not-ready cycles, or faults after TMO of them.
  task automatic access(input int st, input logic [12:0] base, input bit inc, input int d,
                        output bit timed_out);
    timed_out = 1'b0;
    for (int k = 0; k <= d; k++) begin
      if (k == d) begin
        cyc(st, base | (inc ? S_INC : 13'h0), rb(), 1'b1, rir());
      end else begin
        cyc(st, base, rb(), 1'b0, rir());
        if (k == TMO - 1) begin
          timed_out = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic fault_tail();
    mdl_fault = 1'b1;
    repeat (3) cyc(ST_FAULT, 13'h0, rb(), rb(), rir());
  endtask

  task automatic halt_tail();
    mdl_halted = 1'b1;
    repeat (3) cyc(ST_HALT, 13'h0, rb(), rb(), rir());
  endtask

  task automatic start();
    int n;
    n = $urandom_range(0, 2);
    repeat (n) cyc(ST_IDLE, 13'h0, 1'b0, rb(), rir());
    cyc(ST_IDLE, S_EN, 1'b1, rb(), rir());
  endtask

  // Called right after a cyc check: reset lands mid-cycle, before the next rising edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    run = 1'b1;
    #1;
    mdl_halted = 1'b0;
    mdl_fault = 1'b0;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_strobes", 32'(stb), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_state", 32'(state), 32'(ST_IDLE));
    check("rst_hold_strobes", 32'(stb), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;
  endtask

  // Full instruction from F0; term is set when it ends in HALT or FAULT.
  task automatic instr(input logic [7:0] iv, input int d_f, input int d_x, output bit term);
    bit to;
    term = 1'b1;
    cyc(ST_F0, S_PCO | S_MARI, rb(), rb(), rir());
    access(ST_F1, S_MRO | S_DRO | S_DIN, 1'b1, d_f, to);
    if (to) begin
      fault_tail();
      return;
    end
    cyc(ST_F2, S_DOUT | S_IRIN, rb(), rb(), rir());
    cyc(ST_DEC, 13'h0, rb(), rb(), iv);
    case (iv[7:4])
      4'h0: term = 1'b0;
      4'h1: begin
        cyc(ST_LD0, S_IRO | S_MARI, rb(), rb(), rir());
        access(ST_LD1, S_MRO | S_DRO | S_DIN, 1'b0, d_x, to);
        if (to) begin
          fault_tail();
          return;
        end
        cyc(ST_LD2, S_DOUT | S_YIN, rb(), rb(), rir());
        term = 1'b0;
      end
      4'h2: begin
        cyc(ST_ST0, S_IRO | S_MARI, rb(), rb(), rir());
        access(ST_ST1, S_MRO | S_DRIN, 1'b0, d_x, to);
        if (to) begin
          fault_tail();
          return;
        end
        term = 1'b0;
      end
      4'h3: begin
        cyc(ST_JMP, S_IRO | S_PCIN, rb(), rb(), rir());
        term = 1'b0;
      end
      4'hF: halt_tail();
      default: fault_tail();
    endcase
  endtask

  initial begin
    bit term;
    bit to;
    logic [3:0] op;

    #2;
    reset = 1'b0;
    run = 1'b1;
    #1;
    check("init_state", 32'(state), 32'(ST_IDLE));
    check("init_strobes", 32'(stb), 32'h0);
    check("init_halted", 32'(halted), 32'h0);
    check("init_fault", 32'(fault), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;

    // NOP stream with zero-wait memory, then load with 3 waits, then jump.
    start();
    instr(8'h00, 0, 0, term);
    instr(8'h00, 0, 0, term);
    instr(8'h15, 0, 3, term);
    instr(8'h3A, 1, 0, term);
    instr(8'h27, 2, 2, term);

    // Fetch timeout and ready arriving exactly at the limit.
    instr(8'h00, TMO, 0, term);
    do_reset();
    start();
    instr(8'h00, TMO - 1, 0, term);
    instr(8'h1C, 0, TMO - 1, term);
    instr(8'h2C, 0, TMO, term);
    do_reset();

    start();
    instr(8'hF0, 0, 0, term);
    do_reset();
    start();
    instr(8'h70, 0, 0, term);
    do_reset();

    // Reset in the middle of a store wait.
    start();
    cyc(ST_F0, S_PCO | S_MARI, rb(), rb(), rir());
    access(ST_F1, S_MRO | S_DRO | S_DIN, 1'b1, 0, to);
    cyc(ST_F2, S_DOUT | S_IRIN, rb(), rb(), rir());
    cyc(ST_DEC, 13'h0, rb(), rb(), 8'h2C);
    cyc(ST_ST0, S_IRO | S_MARI, rb(), rb(), rir());
    cyc(ST_ST1, S_MRO | S_DRIN, rb(), 1'b0, rir());
    cyc(ST_ST1, S_MRO | S_DRIN, rb(), 1'b0, rir());
    do_reset();
    start();
    instr(8'h00, 0, 0, term);

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = 4'h0;
        2, 3:    op = 4'h1;
        4, 5:    op = 4'h2;
        6, 7:    op = 4'h3;
        8:       op = 4'hF;
        default: op = 4'($urandom_range(4, 14));
      endcase
      instr({op, 4'($urandom)}, rdelay(), rdelay(), term);
      if (term) begin
        do_reset();
        start();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
